// File: rtl/ising_prog_pkg.sv
// Shared types for the Ising weight programmer: FSM encoding, command record
// layout and write-counter width.
package ising_prog_pkg;

  localparam int WR_COUNT_W = 16;
  localparam int ADDR_W     = 32;
  localparam int WDATA_W    = 32;
  localparam int CMD_W      = ADDR_W + WDATA_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [WDATA_W-1:0] data;
    logic               last;
  } cmd_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RDWAIT,
    S_CHECK,
    S_GAP,
    S_NEXT,
    S_HOLD,
    S_RUN
  } state_t;

  // Write counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ising_cmd_fifo.sv
// Command buffer: synchronous FIFO with first-word-fall-through head.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module ising_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rptr_q];

  // Pointer and occupancy update; pointers wrap naturally (power-of-2 depth).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: cleared by reset, which also discards buffered commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/ising_weight_programmer.sv
// Weight-programming initiator for the Ising core. Buffers host (addr, weight)
// commands, issues one-cycle write strobes, holds the core in reset while a
// batch is loading and releases it once the last command has retired.
// Optional readback verification: define ISING_PROG_VERIFY_EN.
module ising_weight_programmer
  import ising_prog_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int WRITE_GAP  = 2,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        axi_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        cmd_last,
  input  logic [31:0] host_rd_addr,
  output logic        wready,
  output logic [31:0] wr_addr,
  output logic [31:0] wdata,
  output logic [31:0] rd_addr,
  input  logic [31:0] rdata,
  output logic        ising_rstn,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] wr_count
);

  // One counter serves both the post-write gap and the readback wait.
  localparam int CNT_MAX = (WRITE_GAP > RD_LATENCY) ? WRITE_GAP : RD_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;
  localparam logic [CNT_W-1:0] GAP_LAST = (WRITE_GAP > 0) ? CNT_W'(WRITE_GAP - 1) : '0;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wready_q, wready_d;
  logic [31:0]             wr_addr_q, wr_addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    last_q, last_d;
  logic                    rstn_q, rstn_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [WR_COUNT_W-1:0]   wr_count_q, wr_count_d;

  cmd_t push_cmd, head_cmd;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign push_cmd  = '{addr: cmd_addr, data: cmd_data, last: cmd_last};
  assign cmd_ready = !fifo_full && !axi_rst;
  assign fifo_push = cmd_valid && cmd_ready;

  ising_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (axi_rst),
    .push      (fifo_push),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .head      (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef ISING_PROG_VERIFY_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LATENCY - 1);
  logic err_q, err_d;
  assign err     = err_q;
  assign rd_addr = (state_q == S_RDWAIT || state_q == S_CHECK) ? wr_addr_q : host_rd_addr;
`else
  logic unused_rdata;
  assign unused_rdata = ^rdata;
  assign err          = 1'b0;
  assign rd_addr      = host_rd_addr;
`endif

  assign wready     = wready_q;
  assign wr_addr    = wr_addr_q;
  assign wdata      = wdata_q;
  assign ising_rstn = rstn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wr_count   = wr_count_q;

  // Next-state and registered-output logic; everything holds by default.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wready_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wdata_d    = wdata_q;
    last_d     = last_q;
    rstn_d     = rstn_q;
    busy_d     = busy_q;
    done_d     = done_q;
    wr_count_d = wr_count_q;
    fifo_pop   = 1'b0;
`ifdef ISING_PROG_VERIFY_EN
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d    = S_LOAD;
          rstn_d     = 1'b0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          wr_count_d = '0;
`ifdef ISING_PROG_VERIFY_EN
          err_d      = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        // Capture the head so the strobe goes out with registered addr/data.
        fifo_pop  = 1'b1;
        wr_addr_d = head_cmd.addr;
        wdata_d   = head_cmd.data;
        last_d    = head_cmd.last;
        wready_d  = 1'b1;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        wr_count_d = sat_inc(wr_count_q);
        cnt_d      = '0;
`ifdef ISING_PROG_VERIFY_EN
        state_d    = S_RDWAIT;
`else
        state_d    = (WRITE_GAP == 0) ? S_NEXT : S_GAP;
`endif
      end
`ifdef ISING_PROG_VERIFY_EN
      S_RDWAIT: begin
        if (cnt_q == RD_LAST) state_d = S_CHECK;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      S_CHECK: begin
        if (rdata != wdata_q) err_d = 1'b1;
        cnt_d   = '0;
        state_d = (WRITE_GAP == 0) ? S_NEXT : S_GAP;
      end
`endif
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_NEXT;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_NEXT: begin
        if (last_q) begin
          state_d = S_RUN;
          rstn_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!fifo_empty) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!fifo_empty) state_d = S_LOAD;
      end
      S_RUN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, all returned to idle by reset.
  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wready_q   <= 1'b0;
      wr_addr_q  <= '0;
      wdata_q    <= '0;
      last_q     <= 1'b0;
      rstn_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_count_q <= '0;
`ifdef ISING_PROG_VERIFY_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wready_q   <= wready_d;
      wr_addr_q  <= wr_addr_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      rstn_q     <= rstn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_count_q <= wr_count_d;
`ifdef ISING_PROG_VERIFY_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ising_weight_programmer.sv
// Directed bench for ising_weight_programmer with a small core memory model.
module tb_ising_weight_programmer;

  localparam int FIFO_DEPTH = 8;
  localparam int WRITE_GAP  = 2;
  localparam int RD_LATENCY = 2;
`ifdef ISING_PROG_VERIFY_EN
  // WRITE, RDWAIT x RD_LATENCY, CHECK, GAP x WRITE_GAP, NEXT, LOAD
  localparam int STROBE_PERIOD = WRITE_GAP + RD_LATENCY + 4;
`else
  // WRITE, GAP x WRITE_GAP, NEXT, LOAD
  localparam int STROBE_PERIOD = WRITE_GAP + 3;
`endif

  logic        clk = 1'b0;
  logic        axi_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_last;
  logic [31:0] host_rd_addr;
  logic        wready;
  logic [31:0] wr_addr;
  logic [31:0] wdata;
  logic [31:0] rd_addr;
  logic [31:0] rdata;
  logic        ising_rstn;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  ising_weight_programmer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WRITE_GAP  (WRITE_GAP),
    .RD_LATENCY (RD_LATENCY)
  ) dut (
    .clk          (clk),
    .axi_rst      (axi_rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_last     (cmd_last),
    .host_rd_addr (host_rd_addr),
    .wready       (wready),
    .wr_addr      (wr_addr),
    .wdata        (wdata),
    .rd_addr      (rd_addr),
    .rdata        (rdata),
    .ising_rstn   (ising_rstn),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .wr_count     (wr_count)
  );

  always #5 clk = ~clk;

  // Strobe log: cycle index, address and data of every wready pulse.
  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } strobe_t;
  strobe_t q[$];
  int cyc_cnt = 0;

  always @(posedge clk) begin
    if (wready) q.push_back('{cyc: cyc_cnt, addr: wr_addr, data: wdata});
    cyc_cnt <= cyc_cnt + 1;
  end

  // Core model: the write to address 0x8 is stored corrupted; reads take two cycles.
  logic [31:0] core_mem [256];
  logic [31:0] rd_p1;
  always @(posedge clk) begin
    if (wready) core_mem[wr_addr[9:2]] <= (wr_addr == 32'h8) ? (wdata ^ 32'h1) : wdata;
    rd_p1 <= core_mem[rd_addr[9:2]];
    rdata <= rd_p1;
  end

  // Present one command right after a negedge; return at the negedge after acceptance.
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] d, input logic l);
    int w;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_last  = l;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (w >= 100) begin
      errors++;
      $display("FAIL send_cmd_timeout addr=%0h waited=%0d limit=100", a, w);
    end
  endtask

  task automatic wait_done(input int limit, input string name);
    int w;
    w = 0;
    while (!(done && !busy) && w < limit) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= limit) begin
      errors++;
      $display("FAIL %s timeout done=%0b busy=%0b expected done=1 busy=0", name, done, busy);
    end
  endtask

  task automatic wait_strobes(input int n, input int limit, input string name);
    int w;
    w = 0;
    while (q.size() < n && w < limit) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (q.size() < n) begin
      errors++;
      $display("FAIL %s strobes=%0d expected>=%0d", name, q.size(), n);
    end
  endtask

  task automatic test_reset();
    axi_rst      = 1'b1;
    cmd_valid    = 1'b0;
    cmd_addr     = '0;
    cmd_data     = '0;
    cmd_last     = 1'b0;
    host_rd_addr = 32'hCAFE0000;
    repeat (3) @(negedge clk);
    checks++; if (wready !== 1'b0)      begin errors++; $display("FAIL rst_wready got=%0h exp=0", wready); end
    checks++; if (wr_addr !== 32'h0)    begin errors++; $display("FAIL rst_wr_addr got=%0h exp=0", wr_addr); end
    checks++; if (wdata !== 32'h0)      begin errors++; $display("FAIL rst_wdata got=%0h exp=0", wdata); end
    checks++; if (ising_rstn !== 1'b0)  begin errors++; $display("FAIL rst_ising_rstn got=%0h exp=0", ising_rstn); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL rst_done got=%0h exp=0", done); end
    checks++; if (err !== 1'b0)         begin errors++; $display("FAIL rst_err got=%0h exp=0", err); end
    checks++; if (wr_count !== 16'h0)   begin errors++; $display("FAIL rst_wr_count got=%0h exp=0", wr_count); end
    checks++; if (cmd_ready !== 1'b0)   begin errors++; $display("FAIL rst_cmd_ready got=%0h exp=0", cmd_ready); end
    axi_rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1)   begin errors++; $display("FAIL post_rst_cmd_ready got=%0h exp=1", cmd_ready); end
    checks++; if (ising_rstn !== 1'b0)  begin errors++; $display("FAIL post_rst_ising_rstn got=%0h exp=0", ising_rstn); end
  endtask

  task automatic test_single();
    q.delete();
    send_cmd(32'h4, 32'h12, 1'b1);
    // state IDLE after the acceptance edge
    checks++; if (wready !== 1'b0)      begin errors++; $display("FAIL single_lat0_wready got=%0h exp=0", wready); end
    @(negedge clk);
    // state LOAD
    checks++; if (wready !== 1'b0)      begin errors++; $display("FAIL single_lat1_wready got=%0h exp=0", wready); end
    checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL single_busy got=%0h exp=1", busy); end
    checks++; if (ising_rstn !== 1'b0)  begin errors++; $display("FAIL single_rstn_low got=%0h exp=0", ising_rstn); end
    @(negedge clk);
    // state WRITE: third edge counting the acceptance edge
    checks++; if (wready !== 1'b1)      begin errors++; $display("FAIL single_strobe got=%0h exp=1", wready); end
    checks++; if (wr_addr !== 32'h4)    begin errors++; $display("FAIL single_wr_addr got=%0h exp=4", wr_addr); end
    checks++; if (wdata !== 32'h12)     begin errors++; $display("FAIL single_wdata got=%0h exp=12", wdata); end
    checks++; if (rd_addr !== host_rd_addr) begin errors++; $display("FAIL single_rd_addr got=%0h exp=%0h", rd_addr, host_rd_addr); end
    @(negedge clk);
    checks++; if (wready !== 1'b0)      begin errors++; $display("FAIL single_strobe_width got=%0h exp=0", wready); end
    checks++; if (wr_count !== 16'd1)   begin errors++; $display("FAIL single_wr_count_early got=%0d exp=1", wr_count); end
    wait_done(50, "single_done");
    checks++; if (ising_rstn !== 1'b1)  begin errors++; $display("FAIL single_rstn_high got=%0h exp=1", ising_rstn); end
    checks++; if (wr_count !== 16'd1)   begin errors++; $display("FAIL single_wr_count got=%0d exp=1", wr_count); end
    checks++; if (q.size() != 1)        begin errors++; $display("FAIL single_strobe_count got=%0d exp=1", q.size()); end
    checks++; if (err !== 1'b0)         begin errors++; $display("FAIL single_err got=%0h exp=0", err); end
  endtask

  // Entered on the first RUN cycle of the previous batch.
  task automatic test_back_to_back();
    int hi;
    q.delete();
    hi = ising_rstn ? 1 : 0;
    cmd_addr  = 32'h20;
    cmd_data  = 32'h55;
    cmd_last  = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (ising_rstn) hi++;
    @(negedge clk);
    checks++; if (ising_rstn !== 1'b0)  begin errors++; $display("FAIL b2b_rstn_fall got=%0h exp=0", ising_rstn); end
    checks++; if (hi != 2)              begin errors++; $display("FAIL b2b_rstn_window got=%0d exp=2", hi); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL b2b_done_clear got=%0h exp=0", done); end
    checks++; if (wr_count !== 16'd0)   begin errors++; $display("FAIL b2b_wr_count_clear got=%0d exp=0", wr_count); end
    wait_done(60, "b2b_done");
    checks++; if (wr_count !== 16'd1)   begin errors++; $display("FAIL b2b_wr_count got=%0d exp=1", wr_count); end
    checks++; if (q.size() < 1 || q[0].addr !== 32'h20) begin errors++; $display("FAIL b2b_addr got_n=%0d exp addr=20", q.size()); end
  endtask

  task automatic test_burst();
    int  i;
    bit  rdy;
    bit  stalled;
    repeat (3) @(negedge clk);
    q.delete();
    i = 0;
    stalled = 0;
    for (int c = 0; c < 300 && i < 12; c++) begin
      cmd_addr  = 32'h100 + 32'(i) * 4;
      cmd_data  = 32'hA000 + 32'(i);
      cmd_last  = (i == 11);
      cmd_valid = 1'b1;
      rdy = cmd_ready;
      @(negedge clk);
      if (rdy) i++;
      if (!cmd_ready && !stalled && i < 12) begin
        stalled = 1;
        // occupancy = accepted minus already-strobed entries
        checks++;
        if (i - q.size() != FIFO_DEPTH) begin
          errors++;
          $display("FAIL burst_full_level got=%0d exp=%0d", i - q.size(), FIFO_DEPTH);
        end
      end
    end
    cmd_valid = 1'b0;
    checks++; if (!stalled)             begin errors++; $display("FAIL burst_backpressure got=0 exp=1"); end
    checks++; if (i != 12)              begin errors++; $display("FAIL burst_accepted got=%0d exp=12", i); end
    wait_done(400, "burst_done");
    checks++; if (wr_count !== 16'd12)  begin errors++; $display("FAIL burst_wr_count got=%0d exp=12", wr_count); end
    checks++; if (q.size() != 12)       begin errors++; $display("FAIL burst_strobes got=%0d exp=12", q.size()); end
    for (int k = 0; k < q.size() && k < 12; k++) begin
      checks++;
      if (q[k].addr !== 32'h100 + 32'(k) * 4 || q[k].data !== 32'hA000 + 32'(k)) begin
        errors++;
        $display("FAIL burst_order_%0d got=%0h/%0h exp=%0h/%0h", k, q[k].addr, q[k].data,
                 32'h100 + 32'(k) * 4, 32'hA000 + 32'(k));
      end
      if (k > 0) begin
        checks++;
        if (q[k].cyc - q[k-1].cyc != STROBE_PERIOD) begin
          errors++;
          $display("FAIL burst_spacing_%0d got=%0d exp=%0d", k, q[k].cyc - q[k-1].cyc, STROBE_PERIOD);
        end
      end
    end
    checks++; if (err !== 1'b0)         begin errors++; $display("FAIL burst_err got=%0h exp=0", err); end
  endtask

  task automatic test_stall();
    int viol;
    int early;
    int w;
    repeat (3) @(negedge clk);
    q.delete();
    for (int k = 0; k < 3; k++) send_cmd(32'h200 + 32'(k) * 4, 32'hB00 + 32'(k), 1'b0);
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (!busy || ising_rstn) viol++;
    end
    checks++; if (viol != 0)            begin errors++; $display("FAIL stall_hold got=%0d bad cycles exp=0", viol); end
    checks++; if (wr_count !== 16'd3)   begin errors++; $display("FAIL stall_wr_count got=%0d exp=3", wr_count); end
    checks++; if (q.size() != 3)        begin errors++; $display("FAIL stall_strobes got=%0d exp=3", q.size()); end
    send_cmd(32'h20C, 32'hB03, 1'b1);
    early = 0;
    w = 0;
    while (!done && w < 100) begin
      if (ising_rstn && q.size() < 4) early++;
      @(negedge clk);
      w++;
    end
    checks++; if (done !== 1'b1)        begin errors++; $display("FAIL stall_done got=%0h exp=1", done); end
    checks++; if (early != 0)           begin errors++; $display("FAIL stall_rstn_early got=%0d exp=0", early); end
    checks++; if (q.size() != 4)        begin errors++; $display("FAIL stall_final_strobes got=%0d exp=4", q.size()); end
    checks++; if (wr_count !== 16'd4)   begin errors++; $display("FAIL stall_final_wr_count got=%0d exp=4", wr_count); end
  endtask

  task automatic test_reset_mid();
    repeat (3) @(negedge clk);
    q.delete();
    for (int k = 0; k < 5; k++) send_cmd(32'h300 + 32'(k) * 4, 32'hC00 + 32'(k), k == 4);
    wait_strobes(2, 100, "rstmid_two_writes");
    axi_rst = 1'b1;
    #1;
    checks++; if (wready !== 1'b0)      begin errors++; $display("FAIL rstmid_wready got=%0h exp=0", wready); end
    checks++; if (wr_addr !== 32'h0)    begin errors++; $display("FAIL rstmid_wr_addr got=%0h exp=0", wr_addr); end
    checks++; if (wdata !== 32'h0)      begin errors++; $display("FAIL rstmid_wdata got=%0h exp=0", wdata); end
    checks++; if (ising_rstn !== 1'b0)  begin errors++; $display("FAIL rstmid_rstn got=%0h exp=0", ising_rstn); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rstmid_busy got=%0h exp=0", busy); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL rstmid_done got=%0h exp=0", done); end
    checks++; if (wr_count !== 16'h0)   begin errors++; $display("FAIL rstmid_wr_count got=%0d exp=0", wr_count); end
    checks++; if (cmd_ready !== 1'b0)   begin errors++; $display("FAIL rstmid_cmd_ready got=%0h exp=0", cmd_ready); end
    repeat (2) @(negedge clk);
    axi_rst = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (q.size() != 2)        begin errors++; $display("FAIL rstmid_no_more_writes got=%0d exp=2", q.size()); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rstmid_idle_busy got=%0h exp=0", busy); end
    checks++; if (ising_rstn !== 1'b0)  begin errors++; $display("FAIL rstmid_idle_rstn got=%0h exp=0", ising_rstn); end
    checks++; if (cmd_ready !== 1'b1)   begin errors++; $display("FAIL rstmid_fifo_empty got=%0h exp=1", cmd_ready); end
  endtask

`ifdef ISING_PROG_VERIFY_EN
  task automatic test_verify();
    repeat (3) @(negedge clk);
    host_rd_addr = 32'hDEAD0000;
    q.delete();
    send_cmd(32'h4, 32'h11, 1'b0);
    send_cmd(32'h8, 32'h22, 1'b0);
    send_cmd(32'hC, 32'h33, 1'b1);
    wait_strobes(1, 100, "verify_first_write");
    checks++; if (rd_addr !== 32'h4)    begin errors++; $display("FAIL verify_rd_addr1 got=%0h exp=4", rd_addr); end
    wait_strobes(2, 100, "verify_second_write");
    checks++; if (err !== 1'b0)         begin errors++; $display("FAIL verify_err_clean got=%0h exp=0", err); end
    checks++; if (rd_addr !== 32'h8)    begin errors++; $display("FAIL verify_rd_addr2 got=%0h exp=8", rd_addr); end
    wait_done(200, "verify_done");
    checks++; if (err !== 1'b1)         begin errors++; $display("FAIL verify_err_set got=%0h exp=1", err); end
    checks++; if (q.size() != 3)        begin errors++; $display("FAIL verify_strobes got=%0d exp=3", q.size()); end
    checks++; if (wr_count !== 16'd3)   begin errors++; $display("FAIL verify_wr_count got=%0d exp=3", wr_count); end
    checks++; if (rd_addr !== 32'hDEAD0000) begin errors++; $display("FAIL verify_rd_passthru got=%0h exp=dead0000", rd_addr); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_burst();
    test_stall();
    test_reset_mid();
`ifdef ISING_PROG_VERIFY_EN
    test_verify();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
